// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared widths, opcodes and IF/ID bundle for the phase-2 pipeline
package wisc_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    localparam logic [3:0]         OPC_HLT      = 4'hF;
    localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 16'h0000;

    // IF/ID pipeline bundle; decode consumes the same layout
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc2;
        logic               valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: BUBBLE_INSTR, pc2: 16'h0000, valid: 1'b0};

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

    // True when the word carries the halt opcode in its top nibble
    function automatic logic is_hlt(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: 4] == OPC_HLT;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// rtl/fetch_stage_pc_reg.sv - program counter register with load enable
import wisc_pkg::*;

module pc_reg #(
    parameter int                WIDTH     = ADDR_W,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled; reset forces the boot address immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with PC, HLT detection and IF/ID register
import wisc_pkg::*;

module fetch_stage #(
    parameter logic [ADDR_W-1:0] PC_RESET = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic [ADDR_W-1:0]  ifid_pc2_o,
    output logic               ifid_valid_o,
    output logic               halt_fetched_o
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus2;
    logic [ADDR_W-1:0] pc_d;
    logic              pc_we;
    logic              fetched_hlt;
    fetch_state_t      state;
    ifid_t             ifid;

    // Sequential successor wraps silently at the top of the address space
    assign pc_plus2    = pc + ADDR_W'(2);
    assign fetched_hlt = is_hlt(imem_data_i);

    // PC update: redirect beats stall; a fetched HLT parks the PC on itself
    always_comb begin
        pc_we = 1'b0;
        pc_d  = pc_plus2;
        if (redirect_i) begin
            pc_we = 1'b1;
            pc_d  = redirect_pc_i;
        end else if (!stall_i && state == ST_FETCH && !fetched_hlt) begin
            pc_we = 1'b1;
            pc_d  = pc_plus2;
        end
    end

    pc_reg #(
        .WIDTH     (ADDR_W),
        .RESET_VAL (PC_RESET)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (pc_we),
        .d     (pc_d),
        .q     (pc)
    );

    // Fetch/halt FSM with the IF/ID register and halt flag as registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_FETCH;
            ifid           <= IFID_BUBBLE;
            halt_fetched_o <= 1'b0;
        end else if (redirect_i) begin
            // Squashes whatever was fetched on the wrong path, including a HLT
            state          <= ST_FETCH;
            ifid           <= IFID_BUBBLE;
            halt_fetched_o <= 1'b0;
        end else if (!stall_i) begin
            case (state)
                ST_FETCH: begin
                    ifid <= '{instr: imem_data_i, pc2: pc_plus2, valid: 1'b1};
                    if (fetched_hlt) begin
                        state          <= ST_HALTED;
                        halt_fetched_o <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    ifid <= IFID_BUBBLE;
                end
                default: begin
                    state <= ST_FETCH;
                    ifid  <= IFID_BUBBLE;
                end
            endcase
        end
    end

    assign pc_o         = pc;
    assign imem_addr_o  = pc;
    assign ifid_instr_o = ifid.instr;
    assign ifid_pc2_o   = ifid.pc2;
    assign ifid_valid_o = ifid.valid;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the phase-2 five-stage pipelined CPU. Holds the PC, drives the instruction-memory read address, detects HLT, and registers the fetched instruction into the IF/ID pipeline register. Its `pc_o` is the value exported on the CPU's top-level `pc` port. Its IF/ID outputs feed decode, which returns branch redirects and hazard stalls.

## Interface
- `PC_RESET`, default 16'h0000: PC value loaded on reset.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall_i` input 1: stall request from the hazard unit; hold PC and IF/ID.
- `redirect_i` input 1: taken branch or jump resolved in ID.
- `redirect_pc_i` input 16: branch/jump target byte address.
- `imem_addr_o` output 16: instruction-memory address; combinationally equal to `pc_o`.
- `imem_data_i` input 16: instruction word; combinational read, valid in the same cycle.
- `pc_o` output 16: current PC register.
- `ifid_instr_o` output 16: registered instruction.
- `ifid_pc2_o` output 16: registered PC+2 of that instruction.
- `ifid_valid_o` output 1: IF/ID holds a real instruction (0 = bubble).
- `halt_fetched_o` output 1: a HLT has been latched into IF/ID and the PC is frozen.

## Operation
- HLT: opcode `imem_data_i[15:12] == 4'hF`.
- `pc_plus2 = pc_o + 2`, modulo 2^16; 0xFFFE wraps to 0x0000 with no flag.
- Next-state priority each cycle: redirect > stall > halted > normal.
  - **redirect**: PC <= `redirect_pc_i`; IF/ID <= bubble (instr 16'h0000, pc2 16'h0000, valid 0); `halt_fetched_o` <= 0. This squashes a wrong-path HLT. Redirect wins even when `stall_i` is 1.
  - **stall** (no redirect): PC, IF/ID and `halt_fetched_o` all hold.
  - **halted** (`halt_fetched_o` = 1, no redirect, no stall):
    - PC holds at the HLT address.
    - IF/ID <= bubble.
  - **normal**:
    - IF/ID <= {`imem_data_i`, `pc_plus2`, valid 1}.
    - If the fetched word is HLT: PC holds (stays on the HLT address) and `halt_fetched_o` <= 1.
    - Otherwise: PC <= `pc_plus2`.
- State machine, two states:
  - FETCH -> HALTED on a HLT fetched in a normal cycle.
  - HALTED -> FETCH only on redirect.
  - Only reset otherwise leaves HALTED.
- Decode gates all side effects on `ifid_valid_o`; opcode 0000 is not treated as a NOP.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `pc_o` = PC_RESET, `imem_addr_o` = PC_RESET.
  - `ifid_instr_o` = 0, `ifid_pc2_o` = 0, `ifid_valid_o` = 0.
  - `halt_fetched_o` = 0.
- First fetch occurs in the first cycle after `rst_n` rises.
- Fetch-to-IF/ID latency: 1 cycle. Address is presented in cycle N, and the word is in IF/ID after edge N.
- Redirect in cycle N: the target is fetched in cycle N+1, and IF/ID carries a bubble during N+1. Taken-branch penalty is 1 bubble.
- A stall of k cycles holds all outputs constant for k edges, with no loss or duplication of instructions.
- `halt_fetched_o` rises on the edge after HLT is present on `imem_data_i`, together with HLT entering IF/ID.
- Reset asserted mid-operation, including while HALTED or stalled: all state returns to reset values asynchronously, and pending redirects are discarded.

## Structure
- Shared package `wisc_pkg` holds:
  - `OPC_HLT` = 4'hF.
  - `BUBBLE_INSTR` = 16'h0000.
  - `INSTR_W` = 16 and `ADDR_W` = 16.
  - The IF/ID bundle typedef {instr, pc2, valid}, reused by decode.
- One natural sub-module: `pc_reg`, a 16-bit register with asynchronous active-low reset to a parameter value and a write enable. Use it for the PC.
- The IF/ID register and halt flag stay inline.

## Test plan
- **Reset and sequential fetch**: release reset, with imem holding ADD words at 0x0000–0x0006.
  - `pc_o` = 0,2,4,6 on successive cycles.
  - `ifid_pc2_o` = 2,4,6 on successive cycles.
  - `ifid_valid_o` = 1 from the second cycle.
- **Stall**: assert `stall_i` for 3 cycles while PC = 0x0004.
  - `pc_o` stays 0x0004 and IF/ID stays unchanged for 3 edges.
  - The next edge latches the word at 0x0004 exactly once.
- **Redirect with stall**: assert `redirect_i` = 1, `redirect_pc_i` = 0x0040 and `stall_i` = 1 together.
  - Next cycle: `pc_o` = 0x0040 and `ifid_valid_o` = 0.
  - Following cycle: IF/ID holds the word at 0x0040 with pc2 = 0x0042.
- **HLT**: place 16'hF000 at 0x000A.
  - `halt_fetched_o` = 1 and `pc_o` stays 0x000A indefinitely.
  - IF/ID = F000 for one cycle, then bubbles.
  - Then a redirect to 0x0020: `halt_fetched_o` = 0 and fetch resumes at 0x0020.
- **Wrap-around**: redirect to 0xFFFE, holding a non-HLT word.
  - Next `pc_o` = 0x0000 and `ifid_pc2_o` = 0x0000.
- **Reset mid-operation**: drop `rst_n` between edges while HALTED at PC 0x000A.
  - All outputs go to reset values immediately, without waiting for a clock edge.
